// File: rtl/driver_monitor_pkg.sv
// Shared types, select codes and dump word layout for the driver monitor readout path.
// Macro DRVMON_DUMP_CHECKSUM_EN adds the CSUM state to the dump sequencer.
package driver_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEL,
        ST_FETCH,
        ST_SEND,
        ST_FOOT,
        ST_DONE
`ifdef DRVMON_DUMP_CHECKSUM_EN
        , ST_CSUM
`endif
    } dump_state_t;

    localparam logic [1:0] ARR_ADDR_MON      = 2'd0;
    localparam logic [1:0] ARR_ADDR_FIFO_MON = 2'd1;
    localparam logic [1:0] ARR_VCTR_MON      = 2'd2;
    localparam logic [1:0] ARR_VCTR_FIFO_MON = 2'd3;

    localparam logic [15:0] HDR_TAG_DEFAULT = 16'hD0A5;

    // Word layout, shared with the host-side decoder model.
    localparam int WORD_TAG_LSB       = 16;
    localparam int WORD_SEQ_LSB       = 8;
    localparam int WORD_NBINS_LSB     = 0;
    localparam int WORD_ARR_LSB       = 30;
    localparam int WORD_IDX_LSB       = 24;
    localparam int WORD_CNT_LSB       = 0;
    localparam int WORD_FOOT_ADDR_LSB = 16;
    localparam int WORD_FOOT_VCTR_LSB = 0;

    function automatic logic [31:0] pack_hdr(input logic [15:0] tag, input logic [7:0] seq,
                                             input logic [7:0] nbins);
        return (32'(tag) << WORD_TAG_LSB) | (32'(seq) << WORD_SEQ_LSB) |
               (32'(nbins) << WORD_NBINS_LSB);
    endfunction

    function automatic logic [31:0] pack_bin(input logic [1:0] arr, input logic [5:0] idx,
                                             input logic [15:0] cnt);
        return (32'(arr) << WORD_ARR_LSB) | (32'(idx) << WORD_IDX_LSB) |
               (32'(cnt) << WORD_CNT_LSB);
    endfunction

    function automatic logic [31:0] pack_foot(input logic [15:0] fill_a, input logic [15:0] fill_v);
        return (32'(fill_a) << WORD_FOOT_ADDR_LSB) | (32'(fill_v) << WORD_FOOT_VCTR_LSB);
    endfunction

    // Array walk order: addr cycle, addr fill, vctr cycle, vctr fill.
    function automatic logic [1:0] next_arr(input logic [1:0] arr);
        case (arr)
            ARR_ADDR_MON:      return ARR_ADDR_FIFO_MON;
            ARR_ADDR_FIFO_MON: return ARR_VCTR_MON;
            ARR_VCTR_MON:      return ARR_VCTR_FIFO_MON;
            default:           return ARR_ADDR_MON;
        endcase
    endfunction

endpackage

// File: rtl/driver_monitor_dump_ctrl.sv
// Readout sequencer: streams header, every histogram bin and a fill footer to the host.
// Macro DRVMON_DUMP_CHECKSUM_EN appends an XOR checksum word that then carries tlast.
module driver_monitor_dump_ctrl
    import driver_monitor_pkg::*;
#(
    parameter int unsigned NUM_BINS         = 16,
    parameter int unsigned CNT_W            = 16,
    parameter int unsigned CLEAR_AFTER_DUMP = 1,
    parameter logic [15:0] HDR_TAG          = HDR_TAG_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_dump,
    input  logic                        end_program,
    input  logic                        auto_en,
    output logic [1:0]                  bin_arr_sel,
    output logic [$clog2(NUM_BINS)-1:0] bin_idx,
    input  logic [CNT_W-1:0]            bin_data,
    input  logic [15:0]                 fill_addr,
    input  logic [15:0]                 fill_vctr,
    output logic [31:0]                 m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        m_tlast,
    output logic                        busy,
    output logic                        freeze,
    output logic                        stats_clr,
    output logic [7:0]                  dump_seq,
    output logic                        trig_drop,
    output logic [2:0]                  dbg_state
);

    localparam int unsigned IDX_W = $clog2(NUM_BINS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BINS - 1);

    // Stream link: a word moves on a cycle with m_tvalid & m_tready; once m_tvalid is
    // raised, m_tdata/m_tlast hold and m_tvalid stays high until that transfer (or reset).

    dump_state_t     state_q, state_d;
    logic [1:0]      arr_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]     foot_q;
    logic [7:0]      dump_seq_q;
    logic            pending_q;
    logic            trig_drop_q;

    logic trig;
    logic xfer;
    logic last_bin;

    assign trig     = start_dump | (auto_en & end_program);
    assign xfer     = m_tvalid & m_tready;
    assign last_bin = (arr_q == ARR_VCTR_FIFO_MON) && (idx_q == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (trig || pending_q) state_d = ST_HDR;
            ST_HDR:   if (m_tready) state_d = ST_SEL;
            ST_SEL:   state_d = ST_FETCH;
            ST_FETCH: state_d = ST_SEND;
            ST_SEND:  if (m_tready) state_d = last_bin ? ST_FOOT : ST_SEL;
`ifdef DRVMON_DUMP_CHECKSUM_EN
            ST_FOOT:  if (m_tready) state_d = ST_CSUM;
            ST_CSUM:  if (m_tready) state_d = ST_DONE;
`else
            ST_FOOT:  if (m_tready) state_d = ST_DONE;
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef DRVMON_DUMP_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (state_q == ST_IDLE) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q ^ m_tdata;
        end
    end
`endif

    always_comb begin
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tlast   = 1'b0;
        stats_clr = 1'b0;
        case (state_q)
            ST_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = pack_hdr(HDR_TAG, dump_seq_q, 8'(NUM_BINS));
            end
            ST_SEND: begin
                m_tvalid = 1'b1;
                m_tdata  = pack_bin(arr_q, 6'(idx_q), 16'(count_q));
            end
            ST_FOOT: begin
                m_tvalid = 1'b1;
                m_tdata  = foot_q;
`ifndef DRVMON_DUMP_CHECKSUM_EN
                m_tlast  = 1'b1;
`endif
            end
`ifdef DRVMON_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                m_tvalid = 1'b1;
                m_tdata  = csum_q;
                m_tlast  = 1'b1;
            end
`endif
            ST_DONE: stats_clr = (CLEAR_AFTER_DUMP != 0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            arr_q       <= ARR_ADDR_MON;
            idx_q       <= '0;
            count_q     <= '0;
            foot_q      <= '0;
            dump_seq_q  <= '0;
            pending_q   <= 1'b0;
            trig_drop_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                arr_q <= ARR_ADDR_MON;
                idx_q <= '0;
            end else if (state_q == ST_SEND && m_tready) begin
                if (idx_q == IDX_LAST) begin
                    idx_q <= '0;
                    arr_q <= next_arr(arr_q);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end

            if (state_q == ST_FETCH) begin
                count_q <= bin_data;
            end

            // Footer fill levels are captured on the edge that enters FOOT.
            if (state_q == ST_SEND && m_tready && last_bin) begin
                foot_q <= pack_foot(fill_addr, fill_vctr);
            end

            if (state_q == ST_DONE) begin
                dump_seq_q <= dump_seq_q + 8'd1;
            end

            // One request may wait behind a running dump; any further one is lost.
            if (state_q == ST_IDLE) begin
                pending_q <= 1'b0;
            end else if (trig) begin
                pending_q <= 1'b1;
                if (pending_q) begin
                    trig_drop_q <= 1'b1;
                end
            end
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign freeze      = (state_q == ST_FETCH) || (state_q == ST_SEND) ||
                         ((state_q == ST_SEL) && ((arr_q != ARR_ADDR_MON) || (idx_q != '0)));
    assign bin_arr_sel = arr_q;
    assign bin_idx     = idx_q;
    assign dump_seq    = dump_seq_q;
    assign trig_drop   = trig_drop_q;
    assign dbg_state   = state_q;

endmodule
